// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity encodings,
// FSM state encodings and a constant-function clog2 used for port/counter widths.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Smallest n with 2**n >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read data. Pointers carry one
// extra MSB so full and empty are distinguished without a separate counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_W data bits LSB first, optional
// parity, 1 or 2 stop bits). Define UART_TX_FIFO_EN to add a word FIFO in front.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              tx_clk,
  input  logic              rst,
  input  logic              tx_enable,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data_in,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic              tx_data_out,
  output logic              done,
  output logic              busy
`ifdef UART_TX_FIFO_EN
  ,
  output logic [clog2(FIFO_DEPTH):0] fifo_level
`endif
);

  localparam int BAUD_W = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
  localparam int IDX_W  = clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  tx_state_t         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [IDX_W-1:0]  bit_idx, idx_next;
  logic              stop_second, stop_next;
  logic              done_next;
  logic              line_q, line_next;
  logic              baud_wrap;
  logic [DATA_W-1:0] data_q;
  logic              par_en_q;
  logic              par_q;
  logic              two_stop_q;
  logic              start_req;
  logic [DATA_W-1:0] src_data;

`ifdef UART_TX_FIFO_EN
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  assign tx_ready  = !fifo_full;
  assign start_req = (state == ST_IDLE) && tx_enable && !fifo_empty;
  assign src_data  = fifo_data;

  uart_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (tx_clk),
    .rst     (rst),
    .push    (tx_valid && tx_ready),
    .wr_data (tx_data_in),
    .pop     (start_req),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );
`else
  assign tx_ready  = tx_enable && (state == ST_IDLE);
  assign start_req = tx_valid && tx_ready;
  assign src_data  = tx_data_in;
`endif

  assign busy        = (state != ST_IDLE);
  assign tx_data_out = line_q;
  assign baud_wrap   = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    idx_next   = bit_idx;
    stop_next  = stop_second;
    done_next  = 1'b0;
    line_next  = 1'b1;

    case (state)
      ST_IDLE: begin
        if (start_req) begin
          state_next = ST_START;
          baud_next  = '0;
          idx_next   = '0;
          stop_next  = 1'b0;
        end
      end
      ST_START: begin
        if (baud_wrap) begin
          state_next = ST_DATA;
          baud_next  = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_wrap) begin
          baud_next = '0;
          if (bit_idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_next = bit_idx + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (baud_wrap) begin
          state_next = ST_STOP;
          baud_next  = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_wrap) begin
          baud_next = '0;
          if (two_stop_q && !stop_second) begin
            stop_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The line is registered from the next state so it changes on the same
    // edge as the FSM and never glitches.
    case (state_next)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = data_q[idx_next];
      ST_PARITY: line_next = par_q;
      default:   line_next = 1'b1;
    endcase
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      stop_second <= 1'b0;
      done        <= 1'b0;
      line_q      <= 1'b1;
    end else begin
      state       <= state_next;
      baud_cnt    <= baud_next;
      bit_idx     <= idx_next;
      stop_second <= stop_next;
      done        <= done_next;
      line_q      <= line_next;
    end
  end

  // Word and frame options are captured once per frame so later input changes
  // cannot disturb a frame already on the line.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (state == ST_IDLE && start_req) begin
      data_q     <= src_data;
      par_en_q   <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_q      <= (parity_mode == PAR_ODD) ? ~^src_data : ^src_data;
      two_stop_q <= two_stop;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (default build, no FIFO):
// a DATA_W=8/CLKS_PER_BIT=4 instance plus a DATA_W=5/CLKS_PER_BIT=2 instance.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       tx_clk = 1'b0;
  logic       rst;
  logic       tx_enable;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data_in;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_data_out;
  logic       done;
  logic       busy;

  logic       d5_enable;
  logic       d5_valid;
  logic       d5_ready;
  logic [4:0] d5_data;
  logic [1:0] d5_mode;
  logic       d5_two;
  logic       d5_line;
  logic       d5_done;
  logic       d5_busy;

  int compared   = 0;
  int mismatched = 0;

`ifdef UART_TX_FIFO_EN
  logic [2:0] fifo_level;
  logic [1:0] d5_level;
`endif

  always #5 tx_clk = ~tx_clk;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .tx_enable   (tx_enable),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data_in  (tx_data_in),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx_data_out (tx_data_out),
    .done        (done),
    .busy        (busy)
`ifdef UART_TX_FIFO_EN
    ,
    .fifo_level  (fifo_level)
`endif
  );

  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(2), .FIFO_DEPTH(2)) u_dut5 (
    .tx_clk      (tx_clk),
    .rst         (rst),
    .tx_enable   (d5_enable),
    .tx_valid    (d5_valid),
    .tx_ready    (d5_ready),
    .tx_data_in  (d5_data),
    .parity_mode (d5_mode),
    .two_stop    (d5_two),
    .tx_data_out (d5_line),
    .done        (d5_done),
    .busy        (d5_busy)
`ifdef UART_TX_FIFO_EN
    ,
    .fifo_level  (d5_level)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one word at a negedge and returns on the transfer edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode, input logic two);
    @(negedge tx_clk);
    tx_data_in  = data;
    parity_mode = mode;
    two_stop    = two;
    tx_valid    = 1'b1;
    checkOutput("ready_at_offer", tx_ready, 1);
    @(posedge tx_clk);
  endtask

  // bits[i] is the i-th serial bit (start first). With chain set, tx_valid stays
  // high and next_data is presented for a transfer in the done cycle.
  task automatic checkFrame(input string tag, input logic [15:0] bits, input int nbits,
                            input logic chain, input logic [7:0] next_data);
    for (int i = 0; i < nbits * CPB; i++) begin
      @(negedge tx_clk);
      if (i == 0) begin
        checkOutput({tag, "_ready_in_frame"}, tx_ready, 0);
        checkOutput({tag, "_no_early_done"}, done, 0);
        if (chain) tx_data_in = next_data;
        else tx_valid = 1'b0;
      end
      checkOutput({tag, "_line"}, tx_data_out, bits[i / CPB]);
      checkOutput({tag, "_busy"}, busy, 1);
    end
    @(negedge tx_clk);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy_end"}, busy, 0);
    checkOutput({tag, "_line_end"}, tx_data_out, 1);
    if (chain) begin
      checkOutput({tag, "_ready_done_cycle"}, tx_ready, 1);
    end else begin
      @(negedge tx_clk);
      checkOutput({tag, "_done_single"}, done, 0);
      checkOutput({tag, "_line_idle"}, tx_data_out, 1);
    end
  endtask

  initial begin
    rst         = 1'b1;
    tx_enable   = 1'b1;
    tx_valid    = 1'b0;
    tx_data_in  = 8'h00;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    d5_enable   = 1'b1;
    d5_valid    = 1'b0;
    d5_data     = 5'h00;
    d5_mode     = 2'b00;
    d5_two      = 1'b0;

    #12;
    checkOutput("reset_line", tx_data_out, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    @(negedge tx_clk);
    rst = 1'b0;
    checkOutput("ready_after_reset", tx_ready, 1);

    // 0xA5 even parity, 1 stop: 0,1,0,1,0,0,1,0,1,0,1
    applyStimulus(8'hA5, 2'b01, 1'b0);
    checkFrame("a5_even", 16'h054A, 11, 1'b0, 8'h00);

    // 0xA5 odd parity, 2 stop: parity 1 then two stop bits; options change mid-frame
    applyStimulus(8'hA5, 2'b10, 1'b1);
    #1;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    checkFrame("a5_odd2", 16'h0F4A, 12, 1'b0, 8'h00);

    // 0x3C then 0xC3, no parity, transfer in the done cycle
    applyStimulus(8'h3C, 2'b00, 1'b0);
    checkFrame("b2b_first", 16'h0278, 10, 1'b1, 8'hC3);
    @(posedge tx_clk);
    checkFrame("b2b_second", 16'h0386, 10, 1'b0, 8'h00);

    // Asynchronous reset while data bit 1 (a zero) is on the line
    applyStimulus(8'hA5, 2'b01, 1'b0);
    @(negedge tx_clk);
    tx_valid = 1'b0;
    repeat (9) @(negedge tx_clk);
    checkOutput("pre_reset_line", tx_data_out, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_line", tx_data_out, 1);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_done", done, 0);
    @(negedge tx_clk);
    rst = 1'b0;
    @(negedge tx_clk);
    checkOutput("post_reset_done", done, 0);
    checkOutput("post_reset_busy", busy, 0);
    applyStimulus(8'h01, 2'b00, 1'b0);
    checkFrame("after_reset", 16'h0202, 10, 1'b0, 8'h00);

    // Enable low with a word offered: nothing is accepted or sent
    @(negedge tx_clk);
    tx_enable  = 1'b0;
    tx_valid   = 1'b1;
    tx_data_in = 8'h55;
    for (int i = 0; i < 8; i++) begin
      @(negedge tx_clk);
      checkOutput("disabled_ready", tx_ready, 0);
      checkOutput("disabled_line", tx_data_out, 1);
      checkOutput("disabled_busy", busy, 0);
    end
    tx_valid  = 1'b0;
    tx_enable = 1'b1;

    // Enable dropped right after the transfer: frame still completes
    applyStimulus(8'h02, 2'b00, 1'b0);
    #1 tx_enable = 1'b0;
    checkFrame("enable_drop", 16'h0204, 10, 1'b0, 8'h00);
    checkOutput("ready_while_disabled", tx_ready, 0);
    tx_enable = 1'b1;
    #1;
    checkOutput("ready_reenabled", tx_ready, 1);

    // DATA_W=5, CLKS_PER_BIT=2: 0x1F even, two stop -> 0,1,1,1,1,1,1,1,1
    @(negedge tx_clk);
    d5_data  = 5'h1F;
    d5_mode  = 2'b01;
    d5_two   = 1'b1;
    d5_valid = 1'b1;
    checkOutput("d5_ready", d5_ready, 1);
    @(posedge tx_clk);
    for (int i = 0; i < 18; i++) begin
      @(negedge tx_clk);
      if (i == 0) d5_valid = 1'b0;
      checkOutput("d5_line", d5_line, (i < 2) ? 0 : 1);
      checkOutput("d5_busy", d5_busy, 1);
    end
    @(negedge tx_clk);
    checkOutput("d5_done", d5_done, 1);
    checkOutput("d5_busy_end", d5_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
